// File: rtl/as2650_extbus_arbiter_pkg.sv
// Shared definitions for the AS2650 external bus arbiter.
// Covers the FSM states, owner encoding and pad direction levels.
package as2650_extbus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LO_SET = 3'd1,
    ST_LO_LAT = 3'd2,
    ST_HI_SET = 3'd3,
    ST_HI_LAT = 3'd4,
    ST_ACCESS = 3'd5,
    ST_END    = 3'd6
  } bus_state_t;

  localparam logic OWN_A   = 1'b0;
  localparam logic OWN_B   = 1'b1;
  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

endpackage

// File: rtl/as2650_extbus_arbiter_rr_arb2.sv
// Two-input round-robin arbiter (rr_arb2) with a last-grant register.
// The last grant resets to B, so A wins the first tie.
module as2650_extbus_arbiter_rr_arb2
  import as2650_extbus_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic gnt_valid,
  output logic gnt_b
);

  logic last_b;

  assign gnt_valid = req_a | req_b;
  // On a tie, the port that was not granted last wins.
  assign gnt_b     = req_b & (~req_a | (last_b == OWN_A));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= OWN_B;
    end else if (take && gnt_valid) begin
      last_b <= gnt_b;
    end
  end

endmodule

// File: rtl/as2650_extbus_arbiter.sv
// Multiplexed 8-bit external memory bus sequencer shared by the CPU (A)
// and the Wishbone host (B). It latches the low and high address bytes, then strobes the access.
module as2650_extbus_arbiter
  import as2650_extbus_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic [7:0]        a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic [7:0]        b_rdata,
  output logic              b_ack,
  input  logic [7:0]        bus_in,
  output logic [7:0]        bus_out,
  output logic              bus_dir,
  output logic              le_lo,
  output logic              le_hi,
  output logic              OEb,
  output logic              WEb,
  output logic              busy,
  output logic              owner_b
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

  bus_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic          cur_we;
  logic [7:0]    cur_addr_hi;
  logic [7:0]    cur_wdata;
  logic          gnt_valid;
  logic          gnt_b;
  logic [15:0]   a_addr16;
  logic [15:0]   b_addr16;
  logic [15:0]   sel_addr;

  assign a_addr16 = 16'(a_addr);
  assign b_addr16 = 16'(b_addr);
  assign sel_addr = gnt_b ? b_addr16 : a_addr16;

  as2650_extbus_arbiter_rr_arb2 u_arb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req_a     (a_req),
    .req_b     (b_req),
    .take      (state == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_b     (gnt_b)
  );

  // Outputs are registered on entry to each state, so they always match the current state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      cur_we      <= 1'b0;
      cur_addr_hi <= '0;
      cur_wdata   <= '0;
      le_lo       <= 1'b0;
      le_hi       <= 1'b0;
      OEb         <= 1'b1;
      WEb         <= 1'b1;
      bus_dir     <= DIR_IN;
      bus_out     <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      owner_b     <= OWN_A;
      busy        <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_b     <= gnt_b;
            cur_we      <= gnt_b ? b_we : a_we;
            cur_wdata   <= gnt_b ? b_wdata : a_wdata;
            cur_addr_hi <= sel_addr[15:8];
            bus_out     <= sel_addr[7:0];
            bus_dir     <= DIR_OUT;
            busy        <= 1'b1;
            state       <= ST_LO_SET;
          end
        end
        ST_LO_SET: begin
          le_lo <= 1'b1;
          state <= ST_LO_LAT;
        end
        ST_LO_LAT: begin
          le_lo   <= 1'b0;
          bus_out <= cur_addr_hi;
          state   <= ST_HI_SET;
        end
        ST_HI_SET: begin
          le_hi <= 1'b1;
          state <= ST_HI_LAT;
        end
        ST_HI_LAT: begin
          le_hi    <= 1'b0;
          wait_cnt <= WAIT_LOAD;
          if (cur_we) begin
            bus_out <= cur_wdata;
            WEb     <= 1'b0;
          end else begin
            bus_dir <= DIR_IN;
            OEb     <= 1'b0;
          end
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (wait_cnt == '0) begin
            OEb <= 1'b1;
            WEb <= 1'b1;
            if (owner_b == OWN_B) begin
              b_ack <= 1'b1;
              if (!cur_we) b_rdata <= bus_in;
            end else begin
              a_ack <= 1'b1;
              if (!cur_we) a_rdata <= bus_in;
            end
            state <= ST_END;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ST_END: begin
          bus_dir <= DIR_IN;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_as2650_extbus_arbiter.sv
// Directed bench for the external bus arbiter; the default build plus
// WAIT_CYCLES=1 and =4 builds for the latency check.
module tb_as2650_extbus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0, bus_in = '0;
  logic [7:0]  a_rdata, b_rdata, bus_out;
  logic        a_ack, b_ack, bus_dir, le_lo, le_hi, OEb, WEb, busy, owner_b;

  logic        a_req1 = 1'b0, a_req4 = 1'b0, no_req = 1'b0;
  logic [7:0]  x1_a_rdata, x1_b_rdata, x1_bus_out, x4_a_rdata, x4_b_rdata, x4_bus_out;
  logic        x1_a_ack, x1_b_ack, x1_bus_dir, x1_le_lo, x1_le_hi, x1_OEb, x1_WEb, x1_busy, x1_owner_b;
  logic        x4_a_ack, x4_b_ack, x4_bus_dir, x4_le_lo, x4_le_hi, x4_OEb, x4_WEb, x4_busy, x4_owner_b;

  int n_checks = 0;
  int n_fail   = 0;

  as2650_extbus_arbiter #(.WAIT_CYCLES(2), .ADDR_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .bus_in(bus_in), .bus_out(bus_out), .bus_dir(bus_dir), .le_lo(le_lo), .le_hi(le_hi),
    .OEb(OEb), .WEb(WEb), .busy(busy), .owner_b(owner_b)
  );

  as2650_extbus_arbiter #(.WAIT_CYCLES(1), .ADDR_W(16)) dut_w1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .a_req(a_req1), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(x1_a_rdata), .a_ack(x1_a_ack),
    .b_req(no_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(x1_b_rdata), .b_ack(x1_b_ack),
    .bus_in(bus_in), .bus_out(x1_bus_out), .bus_dir(x1_bus_dir), .le_lo(x1_le_lo), .le_hi(x1_le_hi),
    .OEb(x1_OEb), .WEb(x1_WEb), .busy(x1_busy), .owner_b(x1_owner_b)
  );

  as2650_extbus_arbiter #(.WAIT_CYCLES(4), .ADDR_W(16)) dut_w4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .a_req(a_req4), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(x4_a_rdata), .a_ack(x4_a_ack),
    .b_req(no_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(x4_b_rdata), .b_ack(x4_b_ack),
    .bus_in(bus_in), .bus_out(x4_bus_out), .bus_dir(x4_bus_dir), .le_lo(x4_le_lo), .le_hi(x4_le_hi),
    .OEb(x4_OEb), .WEb(x4_WEb), .busy(x4_busy), .owner_b(x4_owner_b)
  );

  // Bus invariants checked every cycle outside reset.
  logic prev_a_ack = 1'b0, prev_b_ack = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ((!OEb && !WEb) || (le_lo && le_hi) || (a_ack && b_ack) ||
          (a_ack && prev_a_ack) || (b_ack && prev_b_ack) ||
          ((le_lo || le_hi) && (!OEb || !WEb))) begin
        n_fail++;
        $display("FAIL invariant at %0t: OEb=%b WEb=%b le_lo=%b le_hi=%b a_ack=%b b_ack=%b (prev %b %b)",
                 $time, OEb, WEb, le_lo, le_hi, a_ack, b_ack, prev_a_ack, prev_b_ack);
      end
    end
    prev_a_ack = a_ack;
    prev_b_ack = b_ack;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({le_lo, le_hi, OEb, WEb, bus_dir, a_ack, b_ack, owner_b, busy} !== 9'b001110000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want %b",
               {le_lo, le_hi, OEb, WEb, bus_dir, a_ack, b_ack, owner_b, busy}, 9'b001110000);
    end
    n_checks++;
    if ({bus_out, a_rdata, b_rdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 000000", {bus_out, a_rdata, b_rdata});
    end
    rst = 1'b0;
  endtask

  // ctl vector = {le_lo, le_hi, OEb, WEb, bus_dir, a_ack, b_ack}
  task automatic test_read_a();
    logic [6:0] exp_ctl [1:8];
    logic [7:0] exp_out [1:4];
    exp_ctl = '{7'b0011000, 7'b1011000, 7'b0011000, 7'b0111000,
                7'b0001100, 7'b0001100, 7'b0011110, 7'b0011100};
    exp_out = '{8'hA5, 8'hA5, 8'h12, 8'h12};
    a_we = 1'b0; a_addr = 16'h12A5; bus_in = 8'hEE; a_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({le_lo, le_hi, OEb, WEb, bus_dir, a_ack, b_ack} !== exp_ctl[c]) begin
        n_fail++;
        $display("FAIL read_a_ctl cycle %0d: got %b want %b", c,
                 {le_lo, le_hi, OEb, WEb, bus_dir, a_ack, b_ack}, exp_ctl[c]);
      end
      if (c <= 4) begin
        n_checks++;
        if (bus_out !== exp_out[c]) begin
          n_fail++;
          $display("FAIL read_a_bus_out cycle %0d: got %h want %h", c, bus_out, exp_out[c]);
        end
      end
      if (c == 1) begin
        n_checks++;
        if ({owner_b, busy} !== 2'b01) begin
          n_fail++;
          $display("FAIL read_a_owner: got owner_b/busy %b want 01", {owner_b, busy});
        end
      end
      if (c == 6) bus_in = 8'h3C;
      if (c == 7) begin
        bus_in = 8'h55;
        a_req = 1'b0;
      end
      if (c >= 7) begin
        n_checks++;
        if (a_rdata !== 8'h3C) begin
          n_fail++;
          $display("FAIL read_a_rdata cycle %0d: got %h want 3c", c, a_rdata);
        end
      end
    end
  endtask

  task automatic test_write_b();
    logic [6:0] exp_ctl [1:8];
    logic [7:0] exp_out [1:7];
    exp_ctl = '{7'b0011000, 7'b1011000, 7'b0011000, 7'b0111000,
                7'b0010000, 7'b0010000, 7'b0011001, 7'b0011100};
    exp_out = '{8'h00, 8'h00, 8'h04, 8'h04, 8'h77, 8'h77, 8'h77};
    b_we = 1'b1; b_addr = 16'h0400; b_wdata = 8'h77; b_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({le_lo, le_hi, OEb, WEb, bus_dir, a_ack, b_ack} !== exp_ctl[c]) begin
        n_fail++;
        $display("FAIL write_b_ctl cycle %0d: got %b want %b", c,
                 {le_lo, le_hi, OEb, WEb, bus_dir, a_ack, b_ack}, exp_ctl[c]);
      end
      if (c <= 7) begin
        n_checks++;
        if (bus_out !== exp_out[c]) begin
          n_fail++;
          $display("FAIL write_b_bus_out cycle %0d: got %h want %h", c, bus_out, exp_out[c]);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (owner_b !== 1'b1) begin
          n_fail++;
          $display("FAIL write_b_owner: got %b want 1", owner_b);
        end
      end
      // Changes after the grant must not affect the access in flight.
      if (c == 2) begin
        b_wdata = 8'h99; b_addr = 16'hFFFF; b_we = 1'b0;
      end
      if (c == 7) begin
        b_req = 1'b0;
        n_checks++;
        if ({a_rdata, b_rdata} !== {8'h3C, 8'h00}) begin
          n_fail++;
          $display("FAIL write_b_rdata_hold: got a=%h b=%h want a=3c b=00", a_rdata, b_rdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int when [0:3];
    logic [3:0] seq = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_we = 1'b0; b_we = 1'b0; a_addr = 16'h0010; b_addr = 16'h0020;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 1; c <= 60 && got < 4; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        seq[got] = b_ack;
        when[got] = c;
        got++;
        if (got == 4) begin
          a_req = 1'b0; b_req = 1'b0;
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    n_checks++;
    if (got !== 4) begin
      n_fail++;
      $display("FAIL b2b_ack_count: got %0d acks want 4 within budget", got);
    end else begin
      n_checks++;
      if (seq !== 4'b1010) begin
        n_fail++;
        $display("FAIL b2b_order: got %b (bit0 first, 1=B) want 1010", seq);
      end
      n_checks++;
      if (when[0] !== 7 || when[1] !== 15 || when[3] !== 31) begin
        n_fail++;
        $display("FAIL b2b_timing: got acks at %0d %0d %0d want 7 15 31", when[0], when[1], when[3]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int lat1 = -1;
    int lat4 = -1;
    a_we = 1'b0; a_addr = 16'h0042;
    a_req1 = 1'b1; a_req4 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (x1_a_ack && lat1 < 0) begin lat1 = c; a_req1 = 1'b0; end
      if (x4_a_ack && lat4 < 0) begin lat4 = c; a_req4 = 1'b0; end
    end
    a_req1 = 1'b0; a_req4 = 1'b0;
    n_checks++;
    if (lat1 !== 6) begin
      n_fail++;
      $display("FAIL latency_w1: got %0d want 6", lat1);
    end
    n_checks++;
    if (lat4 !== 9) begin
      n_fail++;
      $display("FAIL latency_w4: got %0d want 9", lat4);
    end
  endtask

  task automatic test_reset_mid_access();
    int ack_at = -1;
    a_we = 1'b0; a_addr = 16'h12A5; a_req = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (OEb !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got OEb=%b want 0", OEb);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({OEb, WEb, bus_dir, le_lo, le_hi, a_ack, busy} !== 7'b1110000) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %b want 1110000", {OEb, WEb, bus_dir, le_lo, le_hi, a_ack, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({a_ack, b_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_noack: got %b want 00", {a_ack, b_ack});
    end
    rst = 1'b0;
    for (int c = 1; c <= 12 && ack_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if ({le_lo, le_hi, OEb, WEb, bus_dir, bus_out} !== {5'b00110, 8'hA5}) begin
          n_fail++;
          $display("FAIL rst_mid_restart: got %b/%h want 00110/a5",
                   {le_lo, le_hi, OEb, WEb, bus_dir}, bus_out);
        end
      end
      if (a_ack) begin
        ack_at = c;
        a_req = 1'b0;
      end
    end
    a_req = 1'b0;
    n_checks++;
    if (ack_at !== 7) begin
      n_fail++;
      $display("FAIL rst_mid_reack: got ack at %0d want 7", ack_at);
    end
  endtask

  initial begin
    test_reset();
    test_read_a();
    test_write_b();
    test_back_to_back();
    test_latency();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
